// File: rtl/frogger_pkg.sv
// Shared constants, FSM state type and lane geometry helpers for the traffic engine.
package frogger_pkg;

    localparam int NUM_CARS   = 8;
    localparam int H_DISPLAY  = 640;
    localparam int CAR_SIZE   = 32;
    localparam int FROG_SIZE  = 32;
    localparam int LANE_Y0    = 128;
    localparam int LANE_PITCH = 64;

    typedef enum logic [1:0] {
        IDLE,
        SEED,
        MOVE,
        REPORT
    } state_t;

    // Two cars per lane: odd car sits half a screen ahead, lanes staggered by 80 px.
    function automatic logic [9:0] init_x(input logic [2:0] i);
        return (i[0] ? 10'(H_DISPLAY / 2) : 10'd0) + 10'(i[2:1]) * 10'd80;
    endfunction

    function automatic logic [9:0] lane_y(input logic [2:0] i);
        return 10'(LANE_Y0) + 10'(i[2:1]) * 10'(LANE_PITCH);
    endfunction

endpackage

// File: rtl/traffic_controller_if.sv
// Frame control, frog position and per-frame result between game logic and the traffic engine.
interface traffic_controller_if;
    logic       frame_tick;
    logic       pause;
    logic [3:0] current_level;
    logic [9:0] frog_x;
    logic [9:0] frog_y;
    logic       update_done;
    logic       hit;

    modport master (
        output frame_tick, pause, current_level, frog_x, frog_y,
        input  update_done, hit
    );

    modport slave (
        input  frame_tick, pause, current_level, frog_x, frog_y,
        output update_done, hit
    );
endinterface

// File: rtl/car_step.sv
// Purpose: advance one car x by step in the given direction, wrapping modulo the display width.
// Latency: combinational.
// Backpressure: none.
module car_step
    import frogger_pkg::*;
(
    input  logic [9:0] x,
    input  logic [4:0] step,
    input  logic       dir,
    output logic [9:0] next_x
);

    logic [10:0] x_w;
    logic [10:0] step_w;
    logic [10:0] sum;
    logic [10:0] res;

    always_comb begin
        x_w    = {1'b0, x};
        step_w = {6'd0, step};
        sum    = x_w + step_w;
        res    = sum;
        if (!dir) begin
            if (sum >= 11'(H_DISPLAY)) begin
                res = sum - 11'(H_DISPLAY);
            end
        end else if (x_w < step_w) begin
            res = x_w + 11'(H_DISPLAY) - step_w;
        end else begin
            res = x_w - step_w;
        end
        next_x = 10'(res);
    end

endmodule

// File: rtl/traffic_controller.sv
// Purpose: per-frame car position update (8 cars, 4 lanes) with frog/car overlap report.
// Latency: move frame 9 cycles tick->update_done, level-change reseed 2 cycles.
// Backpressure: none; frame_tick outside IDLE or while paused is dropped.
module traffic_controller
    import frogger_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    traffic_controller_if.slave  bus,
    output logic [9:0]           car_x_0,
    output logic [9:0]           car_x_1,
    output logic [9:0]           car_x_2,
    output logic [9:0]           car_x_3,
    output logic [9:0]           car_x_4,
    output logic [9:0]           car_x_5,
    output logic [9:0]           car_x_6,
    output logic [9:0]           car_x_7,
    output logic [9:0]           car_y_0,
    output logic [9:0]           car_y_1,
    output logic [9:0]           car_y_2,
    output logic [9:0]           car_y_3,
    output logic [9:0]           car_y_4,
    output logic [9:0]           car_y_5,
    output logic [9:0]           car_y_6,
    output logic [9:0]           car_y_7
);

    state_t      state;
    logic [2:0]  idx;
    logic [3:0]  level_q;
    logic        hit_acc;
    logic [9:0]  car_x_q [NUM_CARS];

    logic [4:0]  step;
    logic [9:0]  next_x;
    logic [10:0] cx;
    logic [10:0] cy;
    logic [10:0] fx;
    logic [10:0] fy;
    logic        overlap;

    // Lane speed grows with lane number and level; level 0 freezes traffic.
    assign step = (level_q == 4'd0) ? 5'd0 : 5'(idx[2:1]) + 5'd1 + 5'(level_q);

    car_step u_car_step (
        .x      (car_x_q[idx]),
        .step   (step),
        .dir    (idx[1]),
        .next_x (next_x)
    );

    assign cx = {1'b0, next_x};
    assign cy = {1'b0, lane_y(idx)};
    assign fx = {1'b0, bus.frog_x};
    assign fy = {1'b0, bus.frog_y};

    assign overlap = (fx < cx + 11'(CAR_SIZE)) && (cx < fx + 11'(FROG_SIZE)) &&
                     (fy < cy + 11'(CAR_SIZE)) && (cy < fy + 11'(FROG_SIZE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            idx             <= 3'd0;
            level_q         <= 4'd0;
            hit_acc         <= 1'b0;
            bus.update_done <= 1'b0;
            bus.hit         <= 1'b0;
            for (int i = 0; i < NUM_CARS; i++) begin
                car_x_q[i] <= init_x(3'(i));
            end
        end else begin
            bus.update_done <= 1'b0;
            bus.hit         <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.frame_tick && !bus.pause) begin
                        if (bus.current_level != level_q) begin
                            state <= SEED;
                        end else begin
                            state   <= MOVE;
                            idx     <= 3'd0;
                            hit_acc <= 1'b0;
                        end
                    end
                end
                SEED: begin
                    for (int i = 0; i < NUM_CARS; i++) begin
                        car_x_q[i] <= init_x(3'(i));
                    end
                    level_q <= bus.current_level;
                    hit_acc <= 1'b0;
                    state   <= REPORT;
                end
                MOVE: begin
                    car_x_q[idx] <= next_x;
                    hit_acc      <= hit_acc | overlap;
                    idx          <= idx + 3'd1;
                    if (idx == 3'd7) begin
                        state <= REPORT;
                    end
                end
                REPORT: begin
                    bus.update_done <= 1'b1;
                    bus.hit         <= hit_acc && (level_q != 4'd0);
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign car_x_0 = car_x_q[0];
    assign car_x_1 = car_x_q[1];
    assign car_x_2 = car_x_q[2];
    assign car_x_3 = car_x_q[3];
    assign car_x_4 = car_x_q[4];
    assign car_x_5 = car_x_q[5];
    assign car_x_6 = car_x_q[6];
    assign car_x_7 = car_x_q[7];

    assign car_y_0 = lane_y(3'd0);
    assign car_y_1 = lane_y(3'd1);
    assign car_y_2 = lane_y(3'd2);
    assign car_y_3 = lane_y(3'd3);
    assign car_y_4 = lane_y(3'd4);
    assign car_y_5 = lane_y(3'd5);
    assign car_y_6 = lane_y(3'd6);
    assign car_y_7 = lane_y(3'd7);

endmodule

// File: tb/tb_traffic_controller.sv
// Directed table of frames plus hand-written wrap, double-tick and mid-update reset sequences.
module tb_traffic_controller;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    initial forever #5 clk = ~clk;

    traffic_controller_if bus();

    wire [9:0] car_x [8];
    wire [9:0] car_y [8];

    traffic_controller dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .car_x_0 (car_x[0]), .car_x_1 (car_x[1]), .car_x_2 (car_x[2]), .car_x_3 (car_x[3]),
        .car_x_4 (car_x[4]), .car_x_5 (car_x[5]), .car_x_6 (car_x[6]), .car_x_7 (car_x[7]),
        .car_y_0 (car_y[0]), .car_y_1 (car_y[1]), .car_y_2 (car_y[2]), .car_y_3 (car_y[3]),
        .car_y_4 (car_y[4]), .car_y_5 (car_y[5]), .car_y_6 (car_y[6]), .car_y_7 (car_y[7])
    );

    typedef struct {
        logic [3:0] level;
        logic       pause;
        logic [9:0] fx;
        logic [9:0] fy;
        int         lat;
        int         hit;
        int         pos;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    int   pos_tab [6][8];
    vec_t vecs [12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_frame(input logic [3:0] lvl, input logic p, input logic [9:0] fx,
                            input logic [9:0] fy, output int lat, output int npulse,
                            output int hit_at, output int stray);
        @(negedge clk);
        bus.current_level = lvl;
        bus.pause         = p;
        bus.frog_x        = fx;
        bus.frog_y        = fy;
        bus.frame_tick    = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        bus.pause      = 1'b0;
        lat    = 0;
        npulse = 0;
        hit_at = 0;
        stray  = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (bus.update_done) begin
                npulse++;
                if (lat == 0) begin
                    lat    = c;
                    hit_at = int'(bus.hit);
                end
            end else if (bus.hit) begin
                stray++;
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, np, ht, st;
        int pulses;

        pos_tab[0] = '{0, 320, 80, 400, 160, 480, 240, 560};
        pos_tab[1] = '{2, 322, 77, 397, 164, 484, 235, 555};
        pos_tab[2] = '{4, 324, 74, 394, 168, 488, 230, 550};
        pos_tab[3] = '{3, 323, 76, 396, 165, 485, 234, 554};
        pos_tab[4] = '{6, 326, 72, 392, 170, 490, 228, 548};
        pos_tab[5] = '{4, 324, 75, 395, 166, 486, 233, 553};

        vecs[0]  = '{4'd1, 1'b0, 10'd600, 10'd10,  2, 0, 0};
        vecs[1]  = '{4'd1, 1'b0, 10'd10,  10'd128, 9, 1, 1};
        vecs[2]  = '{4'd1, 1'b0, 10'd10,  10'd170, 9, 0, 2};
        vecs[3]  = '{4'd1, 1'b1, 10'd10,  10'd128, 0, 0, 2};
        vecs[4]  = '{4'd2, 1'b0, 10'd600, 10'd10,  2, 0, 0};
        vecs[5]  = '{4'd2, 1'b0, 10'd600, 10'd10,  9, 0, 3};
        vecs[6]  = '{4'd2, 1'b0, 10'd380, 10'd192, 9, 1, 4};
        vecs[7]  = '{4'd0, 1'b0, 10'd600, 10'd10,  2, 0, 0};
        vecs[8]  = '{4'd0, 1'b0, 10'd0,   10'd128, 9, 0, 0};
        vecs[9]  = '{4'd3, 1'b0, 10'd600, 10'd10,  2, 0, 0};
        vecs[10] = '{4'd3, 1'b0, 10'd600, 10'd10,  9, 0, 5};
        vecs[11] = '{4'd5, 1'b1, 10'd600, 10'd10,  0, 0, 5};

        bus.frame_tick    = 1'b0;
        bus.pause         = 1'b0;
        bus.current_level = 4'd0;
        bus.frog_x        = 10'd600;
        bus.frog_y        = 10'd10;
        rst_n             = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            chk($sformatf("reset_x%0d", i), int'(car_x[i]), pos_tab[0][i]);
            chk($sformatf("reset_y%0d", i), int'(car_y[i]), 128 + 64 * (i / 2));
        end
        chk("reset_done", int'(bus.update_done), 0);
        chk("reset_hit", int'(bus.hit), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 12; v++) begin
            do_frame(vecs[v].level, vecs[v].pause, vecs[v].fx, vecs[v].fy, lat, np, ht, st);
            chk($sformatf("v%0d_latency", v), lat, vecs[v].lat);
            chk($sformatf("v%0d_pulses", v), np, (vecs[v].lat != 0) ? 1 : 0);
            chk($sformatf("v%0d_hit", v), ht, vecs[v].hit);
            chk($sformatf("v%0d_stray_hit", v), st, 0);
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("v%0d_x%0d", v, i), int'(car_x[i]), pos_tab[vecs[v].pos][i]);
            end
        end

        // Wrap in both directions at level 1.
        do_reset();
        do_frame(4'd1, 1'b0, 10'd600, 10'd10, lat, np, ht, st);
        for (int n = 1; n <= 161; n++) begin
            do_frame(4'd1, 1'b0, 10'd600, 10'd10, lat, np, ht, st);
            if (n == 26)  chk("left_wrap_26",   int'(car_x[2]), 2);
            if (n == 27)  chk("left_wrap_27",   int'(car_x[2]), 639);
            if (n == 160) chk("right_wrap_160", int'(car_x[1]), 0);
            if (n == 161) chk("right_wrap_161", int'(car_x[1]), 2);
        end

        // Second tick while MOVE is in progress is dropped.
        do_reset();
        do_frame(4'd1, 1'b0, 10'd600, 10'd10, lat, np, ht, st);
        @(negedge clk);
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        repeat (2) @(negedge clk);
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.update_done) pulses++;
        end
        chk("double_tick_pulses", pulses, 1);
        chk("double_tick_x0", int'(car_x[0]), 2);
        chk("double_tick_x2", int'(car_x[2]), 77);

        // Reset in the middle of a move frame.
        do_reset();
        do_frame(4'd1, 1'b0, 10'd600, 10'd10, lat, np, ht, st);
        @(negedge clk);
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_move_x3", int'(car_x[3]), 397);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_x0", int'(car_x[0]), 0);
        chk("mid_reset_x3", int'(car_x[3]), 400);
        chk("mid_reset_done", int'(bus.update_done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (bus.update_done) pulses++;
        end
        chk("mid_reset_pulses", pulses, 0);
        chk("mid_reset_x0_after", int'(car_x[0]), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
